// File: rtl/rst_release_seq.sv
// rst_release_seq - multi-channel reset-release sequencer.
//
// Reset assertion on rst_n reaches every channel output asynchronously.
// Deassertion is synchronised to clk and the channels are then released
// one at a time, STAGGER_CYC cycles apart, in index order. Once every
// channel is out of reset, each channel can be pulsed back into reset by
// software for SW_HOLD_CYC cycles.
//
// Ports:
//   clk           sole clock
//   rst_n         asynchronous active-low reset (board pin)
//   sw_rst_req    per-channel soft-reset request, level-sampled on clk
//   ch_rst_n      per-channel active-low reset to downstream flop groups
//   all_released  high when all channels are released and none is in soft reset
//   sw_rst_cnt    saturating count of soft-reset events (0 when counting disabled)
//
// Optional feature macro: RST_SEQ_EVT_CNT_EN
//   defined   -> sw_rst_cnt counts edges on which an accepted request starts or
//                reloads a soft reset (simultaneous channels count once),
//                saturating at 255
//   undefined -> sw_rst_cnt is tied to zero and no counter flops exist
module rst_release_seq #(
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int STAGGER_CYC = 4,
  parameter int SW_HOLD_CYC = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] sw_rst_req,
  output logic [NUM_CH-1:0] ch_rst_n,
  output logic              all_released,
  output logic [7:0]        sw_rst_cnt
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int STG_W = $clog2(STAGGER_CYC + 1);
  localparam int HLD_W = $clog2(SW_HOLD_CYC + 1);

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   sync_rst_n;
  state_e                 state_q, state_d;
  logic [STG_W-1:0]       stag_q, stag_d;
  logic [CH_W-1:0]        next_ch_q, next_ch_d;
  logic [NUM_CH-1:0]      ch_rst_n_q, ch_rst_n_d;
  logic [HLD_W-1:0]       hold_q [NUM_CH];
  logic [HLD_W-1:0]       hold_d [NUM_CH];
  logic                   all_rel_q, all_rel_d;

  // Synchroniser: shifts a constant 1 in; rst_n clears every stage at once.
  assign sync_d     = {sync_q[SYNC_STAGES-2:0], 1'b1};
  assign sync_rst_n = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d    = state_q;
    stag_d     = stag_q;
    next_ch_d  = next_ch_q;
    ch_rst_n_d = ch_rst_n_q;
    for (int i = 0; i < NUM_CH; i++) begin
      hold_d[i] = hold_q[i];
    end

    case (state_q)
      ST_HOLD: begin
        if (sync_rst_n) begin
          // Channel 0 is released on the very edge that leaves HOLD.
          ch_rst_n_d[0] = 1'b1;
          next_ch_d     = CH_W'(1);
          stag_d        = STG_W'(STAGGER_CYC - 1);
          state_d       = (NUM_CH == 1) ? ST_DONE : ST_RELEASE;
        end
      end

      ST_RELEASE: begin
        if (stag_q == '0) begin
          ch_rst_n_d[next_ch_q] = 1'b1;
          stag_d                = STG_W'(STAGGER_CYC - 1);
          if (next_ch_q == CH_W'(NUM_CH - 1)) begin
            state_d = ST_DONE;
          end else begin
            next_ch_d = next_ch_q + 1'b1;
          end
        end else begin
          stag_d = stag_q - 1'b1;
        end
      end

      ST_DONE: begin
        // A request (re)loads the full hold; the channel is low while the
        // counter is non-zero, so a held-high level keeps it low.
        for (int i = 0; i < NUM_CH; i++) begin
          if (sw_rst_req[i]) begin
            hold_d[i] = HLD_W'(SW_HOLD_CYC);
          end else if (hold_q[i] != '0) begin
            hold_d[i] = hold_q[i] - 1'b1;
          end
          ch_rst_n_d[i] = (hold_d[i] == '0);
        end
      end

      default: begin
        state_d = ST_HOLD;
      end
    endcase

    all_rel_d = (state_d == ST_DONE) && (&ch_rst_n_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '0;
      state_q    <= ST_HOLD;
      stag_q     <= '0;
      next_ch_q  <= '0;
      ch_rst_n_q <= '0;
      all_rel_q  <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        hold_q[i] <= '0;
      end
    end else begin
      sync_q     <= sync_d;
      state_q    <= state_d;
      stag_q     <= stag_d;
      next_ch_q  <= next_ch_d;
      ch_rst_n_q <= ch_rst_n_d;
      all_rel_q  <= all_rel_d;
      for (int i = 0; i < NUM_CH; i++) begin
        hold_q[i] <= hold_d[i];
      end
    end
  end

  assign ch_rst_n     = ch_rst_n_q;
  assign all_released = all_rel_q;

`ifdef RST_SEQ_EVT_CNT_EN
  logic       sw_accept;
  logic [7:0] evt_cnt_q, evt_cnt_d;

  // Requests only count when they are actually serviced (DONE state).
  assign sw_accept = (state_q == ST_DONE) && (|sw_rst_req);

  always_comb begin
    evt_cnt_d = evt_cnt_q;
    if (sw_accept && (evt_cnt_q != 8'hFF)) begin
      evt_cnt_d = evt_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_cnt_q <= 8'd0;
    end else begin
      evt_cnt_q <= evt_cnt_d;
    end
  end

  assign sw_rst_cnt = evt_cnt_q;
`else
  assign sw_rst_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_rst_release_seq.sv
// tb_rst_release_seq - randomized self-checking bench for rst_release_seq.
//
// The reference model works purely in terms of edge numbers since the last
// rst_n release: channel i is expected high once the edge count reaches its
// scheduled release edge and SW_HOLD_CYC edges have passed since its last
// accepted soft-reset request. Counting feature follows RST_SEQ_EVT_CNT_EN.
module tb_rst_release_seq;

  localparam int NUM_CH = 4;
  localparam int S      = 2;
  localparam int STAG   = 4;
  localparam int HOLD   = 3;
  localparam int D      = S + 1 + (NUM_CH - 1) * STAG;  // edge of last release

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NUM_CH-1:0] sw_rst_req = '0;
  logic [NUM_CH-1:0] ch_rst_n;
  logic              all_released;
  logic [7:0]        sw_rst_cnt;

  rst_release_seq #(
    .NUM_CH(NUM_CH), .SYNC_STAGES(S), .STAGGER_CYC(STAG), .SW_HOLD_CYC(HOLD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sw_rst_req(sw_rst_req),
    .ch_rst_n(ch_rst_n), .all_released(all_released), .sw_rst_cnt(sw_rst_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit in_rst;
  int k;
  int cnt;
  int last_req [NUM_CH];

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (edge %0d)", tag, got, exp, k);
    end
  endtask

  task automatic model_reset();
    in_rst = 1'b1;
    k      = 0;
    cnt    = 0;
    for (int i = 0; i < NUM_CH; i++) last_req[i] = -1000;
  endtask

  task automatic check_outputs(input string tag);
    logic [NUM_CH-1:0] e;
    int exp_cnt;
    for (int i = 0; i < NUM_CH; i++)
      e[i] = !in_rst && (k >= S + 1 + i * STAG) && (k >= last_req[i] + HOLD);
`ifdef RST_SEQ_EVT_CNT_EN
    exp_cnt = cnt;
`else
    exp_cnt = 0;
`endif
    chk({tag, ".ch_rst_n"}, int'(ch_rst_n), int'(e));
    chk({tag, ".all_released"}, int'(all_released), int'(!in_rst && k >= D && (&e)));
    chk({tag, ".sw_rst_cnt"}, int'(sw_rst_cnt), exp_cnt);
    $display("edge %0d rst=%0b req=%b ch_rst_n=%b all=%0b cnt=%0d",
             k, in_rst, sw_rst_req, ch_rst_n, all_released, sw_rst_cnt);
  endtask

  // One clock edge: advance model with the request seen at the edge, check,
  // then drive a fresh random request with p percent probability per channel.
  task automatic step(input int p);
    @(posedge clk);
    if (!in_rst) begin
      k++;
      if (k >= D + 1) begin
        for (int i = 0; i < NUM_CH; i++) if (sw_rst_req[i]) last_req[i] = k;
        if ((|sw_rst_req) && cnt < 255) cnt++;
      end
    end
    #1;
    check_outputs("step");
    for (int i = 0; i < NUM_CH; i++) sw_rst_req[i] = ($urandom_range(0, 99) < p);
  endtask

  // Called right after step(): release lands 2 ns after the edge.
  task automatic release_rst();
    #1;
    rst_n  = 1'b1;
    in_rst = 1'b0;
    k      = 0;
  endtask

  task automatic assert_rst_async();
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs("async_rst");
  endtask

  initial begin
    int stop_at;
    model_reset();
    #3;
    check_outputs("reset");
    for (int c = 0; c < 3; c++) step(50);

    // Episode 1: full release with requests sprinkled during RELEASE, then
    // sparse soft resets in DONE.
    release_rst();
    for (int c = 0; c < D; c++) step(30);
    for (int c = 0; c < 60; c++) step(10);

    // Episode 2: async reset mid-RELEASE after ch0 and ch1 are released.
    assert_rst_async();
    for (int c = 0; c < 3; c++) step(50);
    release_rst();
    stop_at = $urandom_range(S + 1 + STAG, D - 1);
    while (k < stop_at) step(20);
    assert_rst_async();
    for (int c = 0; c < 2; c++) step(50);
    release_rst();
    for (int c = 0; c < D + 30; c++) step(15);

    // Episode 3: dense requests in DONE to push the event counter past 255.
    for (int c = 0; c < 320; c++) step(60);
    for (int c = 0; c < 10; c++) step(0);
    assert_rst_async();
    step(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
